// File: rtl/ksa_param.sv
// RC4 key-scheduling engine: optional identity fill, then the KSA swap loop over a
// single-port synchronous-read S-memory of 2**ADDR_W entries.
module ksa_param #(
  parameter int unsigned KEY_BYTES = 3,
  parameter int unsigned ADDR_W    = 8,
  parameter bit          DO_INIT   = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  output logic                   rdy,
  output logic                   done,
  input  logic [8*KEY_BYTES-1:0] key,
  output logic [ADDR_W-1:0]      addr,
  input  logic [ADDR_W-1:0]      rddata,
  output logic [ADDR_W-1:0]      wrdata,
  output logic                   wren
);

  localparam int unsigned KW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;

  typedef enum logic [2:0] {
    StIdle,
    StFill,
    StRdI,
    StRdJ,
    StWrI,
    StWrJ,
    StFin
  } state_e;

  state_e                 state_q, state_d;
  logic [ADDR_W-1:0]      i_q, i_d;
  logic [ADDR_W-1:0]      j_q, j_d;
  logic [ADDR_W-1:0]      si_q, si_d;
  logic [KW-1:0]          kidx_q, kidx_d;
  logic [8*KEY_BYTES-1:0] key_q, key_d;

  logic [ADDR_W-1:0] kbyte;
  logic [ADDR_W-1:0] jn;
  logic              start;

  // Key byte 0 is the most significant byte; truncate or zero-extend to ADDR_W.
  always_comb begin
    kbyte = '0;
    for (int unsigned b = 0; b < KEY_BYTES; b++) begin
      if (kidx_q == KW'(b)) begin
        kbyte = ADDR_W'(key_q[8*(KEY_BYTES-1-b) +: 8]);
      end
    end
  end

  assign jn = j_q + rddata + kbyte;

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    si_d    = si_q;
    kidx_d  = kidx_q;
    key_d   = key_q;
    rdy     = 1'b0;
    done    = 1'b0;
    addr    = '0;
    wrdata  = '0;
    wren    = 1'b0;
    start   = 1'b0;

    unique case (state_q)
      StIdle: begin
        rdy   = 1'b1;
        start = en;
      end
      StFill: begin
        addr   = i_q;
        wrdata = i_q;
        wren   = 1'b1;
        i_d    = i_q + ADDR_W'(1);
        if (i_q == {ADDR_W{1'b1}}) begin
          state_d = StRdI;
        end
      end
      StRdI: begin
        addr    = i_q;
        state_d = StRdJ;
      end
      StRdJ: begin
        addr    = jn;
        si_d    = rddata;
        j_d     = jn;
        state_d = StWrI;
      end
      StWrI: begin
        // rddata now holds S[j] from the address presented in StRdJ.
        addr    = i_q;
        wrdata  = rddata;
        wren    = 1'b1;
        state_d = StWrJ;
      end
      StWrJ: begin
        addr   = j_q;
        wrdata = si_q;
        wren   = 1'b1;
        i_d    = i_q + ADDR_W'(1);
        kidx_d = (kidx_q == KW'(KEY_BYTES - 1)) ? '0 : kidx_q + KW'(1);
        state_d = (i_q == {ADDR_W{1'b1}}) ? StFin : StRdI;
      end
      StFin: begin
        rdy     = 1'b1;
        done    = 1'b1;
        state_d = StIdle;
        start   = en;
      end
      default: state_d = StIdle;
    endcase

    if (start) begin
      key_d   = key;
      i_d     = '0;
      j_d     = '0;
      kidx_d  = '0;
      state_d = DO_INIT ? StFill : StRdI;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      i_q     <= '0;
      j_q     <= '0;
      si_q    <= '0;
      kidx_q  <= '0;
      key_q   <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      si_q    <= si_d;
      kidx_q  <= kidx_d;
      key_q   <= key_d;
    end
  end

endmodule
